// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: fetch/issue front end of the instruction decoder.
// Fetches 16-bit words from a synchronous instruction memory, latches them in
// an instruction register and keeps the decoder enabled until the execution
// unit reports completion. NOP and HALT are handled here and never reach the
// decoder.
// Optional feature: define FETCH_ISSUE_TIMEOUT_EN to add an EXEC watchdog that
// raises a sticky fault and halts when exec_done never arrives.
`timescale 1ns/1ps

module fetch_issue_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_ISSUE_TIMEOUT_EN
    ,
    parameter int                TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic              dec_enable,
    output logic [3:0]        op_code,
    output logic [3:0]        ra,
    output logic [3:0]        rb,
    output logic [7:0]        imm8,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        EXEC,
        HALTED
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'b1110;
    localparam logic [3:0] OP_NOP_A = 4'b1100;
    localparam logic [3:0] OP_NOP_B = 4'b1101;

    state_t      state;
    logic [15:0] ir;
    logic        is_halt;
    logic        is_nop;
    logic        timeout;

    // Decoder-facing fields come straight from the instruction register, so
    // they stay stable for the whole EXEC phase.
    assign op_code   = ir[15:12];
    assign ra        = ir[11:8];
    assign rb        = ir[7:4];
    assign imm8      = ir[7:0];
    assign imem_addr = pc;

    assign is_halt = (ir[15:12] == OP_HALT);
    assign is_nop  = (ir[15:12] == OP_NOP_A) || (ir[15:12] == OP_NOP_B);

`ifdef FETCH_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] exec_cnt;

    // Asserted during the last permitted EXEC cycle when no completion came.
    assign timeout = (state == EXEC) && (exec_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts EXEC cycles of the current instruction, latches fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_cnt <= '0;
            fault    <= 1'b0;
        end else if (state == DECODE) begin
            exec_cnt <= '0;
        end else if ((state == EXEC) && !exec_done) begin
            if (timeout) begin
                fault <= 1'b1;
            end else begin
                exec_cnt <= exec_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign fault   = 1'b0;
`endif

    // Main sequencer: state, pc, ir and all strobes are registered together.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in this block sees the pre-edge values of the others.
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= 16'h0000;
            imem_en    <= 1'b0;
            dec_enable <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= FETCH;
                        imem_en <= 1'b1;
                    end
                end
                FETCH: begin
                    state   <= WAIT;
                    imem_en <= 1'b0;
                end
                WAIT: begin
                    ir    <= imem_rdata;
                    state <= DECODE;
                end
                DECODE: begin
                    if (is_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (is_nop) begin
                        pc      <= pc + ADDR_W'(1);
                        state   <= run ? FETCH : IDLE;
                        imem_en <= run;
                    end else begin
                        state      <= EXEC;
                        dec_enable <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        pc         <= pc + ADDR_W'(1);
                        dec_enable <= 1'b0;
                        state      <= run ? FETCH : IDLE;
                        imem_en    <= run;
                    end else if (timeout) begin
                        dec_enable <= 1'b0;
                        halted     <= 1'b1;
                        state      <= HALTED;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit: directed scenarios plus a random program run, checked
// against a transaction-level model (expected pc and per-instruction timing).
`timescale 1ns/1ps

module tb_fetch_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        exec_done = 1'b0;

    // Main instance (RESET_PC = 0)
    logic        imem_en, dec_enable, halted, fault;
    logic [7:0]  imem_addr, pc, imm8;
    logic [3:0]  op_code, ra, rb;
    logic [15:0] imem_rdata;

    // Wrap instance (RESET_PC = 8'hFF)
    logic        w_imem_en, w_dec_enable, w_halted, w_fault;
    logic [7:0]  w_imem_addr, w_pc, w_imm8;
    logic [3:0]  w_op_code, w_ra, w_rb;
    logic [15:0] w_imem_rdata;

    logic [15:0] mem [256];
    logic [7:0]  model_pc;
    int          total = 0;
    int          bad   = 0;

    fetch_issue_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_enable(dec_enable), .op_code(op_code), .ra(ra), .rb(rb), .imm8(imm8),
        .exec_done(exec_done), .pc(pc), .halted(halted), .fault(fault)
    );

    fetch_issue_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) dut_w (
        .clk(clk), .rst(rst), .run(run),
        .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .dec_enable(w_dec_enable), .op_code(w_op_code), .ra(w_ra), .rb(w_rb), .imm8(w_imm8),
        .exec_done(exec_done), .pc(w_pc), .halted(w_halted), .fault(w_fault)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem[imem_addr];
        if (w_imem_en) w_imem_rdata <= mem[w_imem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        exec_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_pc = 8'h00;
    endtask

    // From IDLE: FETCH must follow one cycle after run is raised.
    task automatic start_run();
        run = 1'b1;
        step();
        check("fetch_start", imem_en, 1);
    endtask

    // Precondition: DUT is in FETCH. Runs one instruction through the model.
    // d = EXEC cycles before the exec_done cycle; run_after = run level while
    // the instruction finishes.
    task automatic do_instr(input int d, input logic run_after);
        logic [15:0] w;
        logic [3:0]  opc;
        w   = mem[model_pc];
        opc = w[15:12];
        check("fetch_addr", imem_addr, model_pc);
        step();
        step();
        if (opc == 4'hC || opc == 4'hD) run = run_after;
        step();
        if (opc == 4'hE) begin
            check("halt_flag", halted, 1);
            check("halt_dec", dec_enable, 0);
            check("halt_pc", pc, model_pc);
        end else if (opc == 4'hC || opc == 4'hD) begin
            model_pc = model_pc + 8'd1;
            check("nop_dec", dec_enable, 0);
            check("nop_pc", pc, model_pc);
            check("nop_next_fetch", imem_en, run_after);
        end else begin
            run = run_after;
            check("exec_dec", dec_enable, 1);
            check("exec_fields", {op_code, ra, rb, imm8}, {w[15:12], w[11:8], w[7:4], w[7:0]});
            for (int i = 0; i < d; i++) begin
                step();
                check("exec_hold", {dec_enable, op_code}, {1'b1, w[15:12]});
            end
            exec_done = 1'b1;
            step();
            exec_done = 1'b0;
            model_pc = model_pc + 8'd1;
            check("retire_dec", dec_enable, 0);
            check("retire_pc", pc, model_pc);
            check("retire_next_fetch", imem_en, run_after);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;

        // Reset state
        do_reset();
        check("rst_imem_en", imem_en, 0);
        check("rst_dec", dec_enable, 0);
        check("rst_pc", pc, 8'h00);
        check("rst_ir", {op_code, ra, rb, imm8}, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        check("rst_pc_w", w_pc, 8'hFF);

        // ALU op, exec_done on 2nd EXEC cycle; then NOP, load with run
        // dropped during EXEC, resume, HALT.
        mem[0] = 16'h0123;
        mem[1] = 16'hC000;
        mem[2] = 16'h5678;
        mem[3] = 16'hA450;
        mem[4] = 16'hE000;
        start_run();
        do_instr(1, 1'b1);
        do_instr(0, 1'b1);
        do_instr(2, 1'b1);
        do_instr(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("parked_no_fetch", imem_en, 0);
            check("parked_pc", pc, 8'h04);
        end
        start_run();
        do_instr(0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            exec_done = i[0];
            step();
            check("halt_sticky", {halted, dec_enable, imem_en, pc}, {1'b1, 1'b0, 1'b0, 8'h04});
        end
        exec_done = 1'b0;

        // NOP then HALT: decoder never enabled, pc=1 at HALT
        do_reset();
        mem[0] = 16'hC000;
        mem[1] = 16'hE000;
        start_run();
        do_instr(0, 1'b1);
        do_instr(0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            exec_done = ~i[0];
            step();
            check("halt2_sticky", {halted, dec_enable, imem_en, pc}, {1'b1, 1'b0, 1'b0, 8'h01});
        end
        exec_done = 1'b0;

        // Reset on 2nd EXEC cycle, then exec_done in IDLE is ignored
        do_reset();
        mem[0] = 16'h0123;
        start_run();
        step();
        step();
        step();
        check("rst_exec_dec1", dec_enable, 1);
        step();
        check("rst_exec_dec2", dec_enable, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b0;
        check("rst_mid_dec", dec_enable, 0);
        check("rst_mid_pc", pc, 8'h00);
        check("rst_mid_ir", {op_code, ra, rb, imm8}, 0);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        step();
        check("idle_ignore_done", {dec_enable, imem_en, halted, pc}, {1'b0, 1'b0, 1'b0, 8'h00});

        // PC wrap on the RESET_PC=FF instance
        do_reset();
        mem[8'hFF] = 16'hF0AA;
        mem[0]     = 16'hE000;
        run = 1'b1;
        step();
        check("wrap_fetch", {w_imem_en, w_imem_addr}, {1'b1, 8'hFF});
        step();
        step();
        step();
        check("wrap_exec", {w_dec_enable, w_op_code, w_imm8}, {1'b1, 4'hF, 8'hAA});
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check("wrap_pc", w_pc, 8'h00);
        check("wrap_next_fetch", {w_imem_en, w_imem_addr, w_dec_enable}, {1'b1, 8'h00, 1'b0});

        // Random program against the model
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [15:0] rw;
            rw = 16'($urandom);
            if (rw[15:12] == 4'hE) rw[15:12] = 4'h0;
            mem[i] = rw;
        end
        start_run();
        for (int n = 0; n < 40; n++) begin
            logic keep;
            keep = ($urandom_range(0, 3) != 0);
            do_instr(int'($urandom_range(0, 3)), keep);
            if (!keep) begin
                step();
                check("rand_parked", {imem_en, dec_enable}, 0);
                start_run();
            end
        end

        // Hung execution unit
        do_reset();
        mem[0] = 16'h0123;
        start_run();
        step();
        step();
        step();
        begin
            int hi;
            hi = 0;
            for (int i = 0; i < 220 && dec_enable; i++) begin
                hi++;
                step();
            end
`ifdef FETCH_ISSUE_TIMEOUT_EN
            check("to_cycles", hi, 64);
            check("to_state", {fault, halted, dec_enable, pc}, {1'b1, 1'b1, 1'b0, 8'h00});
`else
            check("noto_cycles", hi, 220);
            check("noto_state", {fault, halted, dec_enable, pc}, {1'b0, 1'b0, 1'b1, 8'h00});
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Upstream stage of the instruction decoder: fetches 16-bit instructions from a synchronous instruction memory, holds each in an instruction register, and drives the decoder's enable and opCode inputs.
- Holds the decoder enabled until the selected execution unit reports completion, then advances the PC.
- Handles the opcodes the decoder does not map itself (NOP, HALT), so the decoder is never enabled with an unmapped opcode.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT_CYCLES, 64, maximum EXEC cycles before fault (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- run  in  1  level; permits fetching of new instructions.
- imem_en  out  1  instruction-memory read strobe.
- imem_addr  out  ADDR_W  read address (= pc).
- imem_rdata  in  16  instruction word; valid the cycle after imem_en.
- dec_enable  out  1  to decoder enable.
- op_code  out  4  to decoder opCode; ir[15:12].
- ra  out  4  ir[11:8], operand field to datapath.
- rb  out  4  ir[7:4], operand field to datapath.
- imm8  out  8  ir[7:0], immediate to datapath.
- exec_done  in  1  one-cycle pulse from the active execution unit.
- pc  out  ADDR_W  current program counter.
- halted  out  1  HALT retired; sticky until rst.
- fault  out  1  sticky; optional feature only, otherwise tied 0.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, ir=16'h0000, imem_en=0, dec_enable=0, halted=0, fault=0. Reset has priority over all activity, including mid-EXEC: dec_enable drops the cycle after rst is sampled.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- States: IDLE, FETCH, WAIT, DECODE, EXEC, HALTED.
- IDLE: all strobes 0. Goes to FETCH when run=1.
- FETCH: imem_en=1, imem_addr=pc. Always goes to WAIT.
- WAIT: ir <= imem_rdata. Goes to DECODE.
- DECODE, opcode class from ir[15:12]:
  - 4'b1110 HALT: go to HALTED.
  - 4'b1100 or 4'b1101 NOP: pc <= pc+1; go to FETCH if run=1, else IDLE.
  - All other opcodes (0000-1011, 1111): go to EXEC.
- EXEC: dec_enable=1; op_code, ra, rb and imm8 are held stable from ir.
  - On exec_done=1: pc <= pc+1; go to FETCH if run=1, else IDLE. dec_enable is 0 in the following cycle.
  - exec_done arriving in the same cycle EXEC is entered counts; it is sampled while state==EXEC.
- exec_done in any state other than EXEC is ignored.
- HALTED: halted=1, dec_enable=0, imem_en=0. Remains until rst; run is ignored.
- PC increments modulo 2^ADDR_W: (2^ADDR_W)-1 wraps to 0.
- run deasserted mid-instruction: the current instruction completes; the block then parks in IDLE. The PC of the next instruction is preserved, and run=1 resumes from it.
- Minimum instruction period: 4 cycles (FETCH, WAIT, DECODE, EXEC with immediate exec_done). NOP takes 3 cycles.
- ir is written only in WAIT.

Optional Feature:
- Macro: FETCH_ISSUE_TIMEOUT_EN.
- Defined:
  - An EXEC cycle counter clears on EXEC entry and increments each EXEC cycle.
  - If the counter reaches TIMEOUT_CYCLES without exec_done: fault <= 1, dec_enable <= 0, state goes to HALTED with halted=1, and pc is not advanced.
  - exec_done in the same cycle as the limit wins: the instruction retires normally.
- Undefined: no counter is built, fault is constant 0, and EXEC waits indefinitely.

Test Plan:
- Reset, run=1, mem[0]=16'h0123 (ALU opcode 0), exec_done pulsed on 2nd EXEC cycle -> imem_en on cycle 1 with addr 0; dec_enable high exactly 2 cycles with op_code=0, ra=1, rb=2, imm8=8'h23; pc=1 afterwards; next FETCH addr=1.
- mem[0]=16'hC000 (NOP), mem[1]=16'hE000 (HALT) -> dec_enable never asserted; pc=1 when HALT decodes; halted=1 and stays 1 over 20 further cycles with run=1 and exec_done pulses.
- ADDR_W=8, RESET_PC=8'hFF, mem[FF]=16'hF0AA (movi), exec_done immediate -> pc wraps to 8'h00, next imem_addr=0.
- run dropped during EXEC of mem[3]=16'hA450 (load) -> instruction retires on exec_done, state IDLE, pc=4, no imem_en until run=1; then fetch addr=4.
- rst asserted on 2nd EXEC cycle -> next cycle dec_enable=0, pc=RESET_PC, ir=0; a subsequent exec_done pulse in IDLE is ignored.
- With FETCH_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=64, no exec_done -> after 64 EXEC cycles fault=1, halted=1, dec_enable=0, pc unchanged; without the macro, dec_enable remains 1 for 200+ cycles and fault=0.
